// File: rtl/nar_pkg.sv
// ============================================================================
// Module : nar_pkg
// Shared FSM encoding, default Q-format widths and saturation bounds for the
// neuron accumulator sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nar_pkg;

  localparam int N_DEF = 10;
  localparam int Q_DEF = 9;

  typedef logic [2:0] nar_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_BIAS  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic signed [N_DEF-1:0] SAT_MAX_DEF = 10'sd511;
  localparam logic signed [N_DEF-1:0] SAT_MIN_DEF = -10'sd512;

endpackage

`default_nettype wire

// File: rtl/neuron_mac_sequencer_qmul_sat.sv
// ============================================================================
// Module : qmul_sat
// Combinational signed N x N Q-format multiply: full product, arithmetic
// shift right by Q (floor), then saturate to the signed N-bit range.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module qmul_sat
  import nar_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic signed [N-1:0] i_a,
  input  logic signed [N-1:0] i_b,
  output logic signed [N-1:0] o_p
);

  localparam int W2 = 2 * N;
  localparam logic signed [W2-1:0] c_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [W2-1:0] c_MIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [W2-1:0] w_a;
  logic signed [W2-1:0] w_b;
  logic signed [W2-1:0] w_full;
  logic signed [W2-1:0] w_shr;

  // Operands are widened first so the product is exact in 2N bits.
  assign w_a    = W2'(i_a);
  assign w_b    = W2'(i_b);
  assign w_full = w_a * w_b;
  assign w_shr  = w_full >>> Q;

  assign o_p = (w_shr > c_MAX) ? c_MAX[N-1:0] :
               (w_shr < c_MIN) ? c_MIN[N-1:0] : w_shr[N-1:0];

endmodule

`default_nettype wire

// File: rtl/neuron_mac_sequencer.sv
// ============================================================================
// Module : neuron_mac_sequencer
// Sequences one neuron evaluation over an external accumulator: fetches
// (x, w) pairs, strobes Q-format products, returns the sum on valid/ready.
// Optional feature macro: NEURON_BIAS_EN (adds b_data port and BIAS state).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module neuron_mac_sequencer
  import nar_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int Q          = Q_DEF,
  parameter int NUM_INPUTS = 8,
  parameter int ADDR_W     = $clog2(NUM_INPUTS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              start_rdy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [N-1:0]      x_data,
  input  logic [N-1:0]      w_data,
`ifdef NEURON_BIAS_EN
  input  logic [N-1:0]      b_data,
`endif
  output logic              acc_rst,
  output logic              acc_add,
  output logic [N-1:0]      acc_a,
  input  logic [N-1:0]      acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NUM_INPUTS - 1);
  localparam logic [ADDR_W-1:0] c_NUM  = ADDR_W'(NUM_INPUTS);

  nar_state_t        r_state;
  logic [ADDR_W-1:0] r_k;
  logic [ADDR_W-1:0] w_k_next;
  logic              w_more;
  logic [N-1:0]      r_out_data;
  logic [N-1:0]      w_prod;

  assign w_k_next = r_k + ADDR_W'(1);
  assign w_more   = (w_k_next < c_NUM);

  qmul_sat #(
    .N (N),
    .Q (Q)
  ) u_qmul_sat (
    .i_a (x_data),
    .i_b (w_data),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          r_k     <= '0;
          r_state <= ST_MAC;
        end
        ST_MAC: begin
          r_k <= w_k_next;
          if (r_k == c_LAST) begin
`ifdef NEURON_BIAS_EN
            r_state <= ST_BIAS;
`else
            r_state <= ST_DRAIN;
`endif
          end
        end
`ifdef NEURON_BIAS_EN
        ST_BIAS: begin
          r_state <= ST_DRAIN;
        end
`endif
        ST_DRAIN: begin
          r_out_data <= acc_out;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode from state so an async reset clears them immediately.
  always_comb begin
    start_rdy = (r_state == ST_IDLE);
    mem_en    = 1'b0;
    mem_addr  = '0;
    acc_rst   = 1'b0;
    acc_add   = 1'b0;
    acc_a     = '0;
    out_valid = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        acc_rst = 1'b1;
        mem_en  = 1'b1;
      end
      ST_MAC: begin
        acc_add = 1'b1;
        acc_a   = w_prod;
        if (w_more) begin
          mem_en   = 1'b1;
          mem_addr = w_k_next;
        end
      end
`ifdef NEURON_BIAS_EN
      ST_BIAS: begin
        acc_add = 1'b1;
        acc_a   = b_data;
      end
`endif
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = r_out_data;

endmodule

`default_nettype wire
